// File: rtl/i2s_arb_pkg.sv
// Shared types and defaults for the I2S source arbiter: FSM state encoding,
// underrun counter width and default parameter values.
package i2s_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    localparam int UNDERRUN_W  = 16;
    localparam int BURST_CNT_W = 8;
    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_BURST   = 4;

endpackage

// File: rtl/i2s_src_arbiter_rr.sv
// Rotating-priority picker: selects the first requester after last_id,
// wrapping around. Purely combinational.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_id,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id
);

    always_comb begin
        logic [ID_W-1:0] idx;
        // NOTE: every output gets a default before any conditional write, so no latch is inferred.
        gnt_valid = |req;
        gnt_id    = '0;
        idx       = '0;
        // Walk from farthest to nearest so the nearest requester overwrites last.
        for (int d = N; d >= 1; d--) begin
            idx = ID_W'((int'(last_id) + d) % N);
            if (req[idx]) begin
                gnt_id = idx;
            end
        end
    end

endmodule

// File: rtl/i2s_src_arbiter.sv
// Round-robin scheduler sharing the stereo TX FIFO pair between audio sources.
// Define I2S_ARB_UNDERRUN_EN to insert zero pairs when the FIFOs run dry.
module i2s_src_arbiter
    import i2s_arb_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BURST   = DEF_BURST
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_enable,
    input  logic [NUM_SRC-1:0]          i_en_mask,
    input  logic [NUM_SRC-1:0]          i_src_valid,
    input  logic [NUM_SRC*DATA_W-1:0]   i_src_left,
    input  logic [NUM_SRC*DATA_W-1:0]   i_src_right,
    output logic [NUM_SRC-1:0]          o_src_ready,
    input  logic                        i_fifol_full,
    input  logic                        i_fifor_full,
    input  logic                        i_fifol_empty,
    input  logic                        i_fifor_empty,
    output logic                        o_txl_wr,
    output logic                        o_txr_wr,
    output logic [DATA_W-1:0]           o_txl_data,
    output logic [DATA_W-1:0]           o_txr_data,
    output logic                        o_grant_valid,
    output logic [$clog2(NUM_SRC)-1:0]  o_grant_id,
    output logic [UNDERRUN_W-1:0]       o_underrun_cnt
);

    localparam int ID_W = $clog2(NUM_SRC);

    arb_state_t             state_q, state_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic [ID_W-1:0]        last_id_q, last_id_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [NUM_SRC-1:0]     eligible;
    logic                   rr_valid;
    logic [ID_W-1:0]        rr_id;
    logic                   xfer;
    logic                   fill;

    assign eligible = {NUM_SRC{i_enable}} & i_en_mask & i_src_valid;

    rr_arbiter #(
        .N    (NUM_SRC),
        .ID_W (ID_W)
    ) u_rr (
        .req       (eligible),
        .last_id   (last_id_q),
        .gnt_valid (rr_valid),
        .gnt_id    (rr_id)
    );

    // Both FIFOs must have room: a pair is only ever written as a whole.
    assign xfer = (state_q == ARB_GRANT) & eligible[grant_id_q]
                & ~i_fifol_full & ~i_fifor_full;

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (rr_valid) begin
                    grant_id_d  = rr_id;
                    burst_cnt_d = BURST_CNT_W'(BURST - 1);
                    state_d     = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!eligible[grant_id_q] || (xfer && burst_cnt_q == '0)) begin
                    state_d   = ARB_IDLE;
                    last_id_d = grant_id_q;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ARB_IDLE;
            grant_id_q  <= '0;
            last_id_q   <= ID_W'(NUM_SRC - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        o_src_ready = '0;
        if (xfer) begin
            o_src_ready[grant_id_q] = 1'b1;
        end
    end

    assign o_txl_wr      = xfer | fill;
    assign o_txr_wr      = xfer | fill;
    assign o_txl_data    = xfer ? i_src_left[grant_id_q*DATA_W +: DATA_W]  : '0;
    assign o_txr_data    = xfer ? i_src_right[grant_id_q*DATA_W +: DATA_W] : '0;
    assign o_grant_valid = (state_q == ARB_GRANT);
    assign o_grant_id    = o_grant_valid ? grant_id_q : '0;

`ifdef I2S_ARB_UNDERRUN_EN
    logic [UNDERRUN_W-1:0] underrun_cnt_q;

    // Starved output: pad with silence rather than let the transmitter underrun.
    assign fill = (state_q == ARB_IDLE) & i_enable & i_fifol_empty & i_fifor_empty
                & ~(|eligible);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            underrun_cnt_q <= '0;
        end else if (fill && underrun_cnt_q != '1) begin
            underrun_cnt_q <= underrun_cnt_q + 1'b1;
        end
    end

    assign o_underrun_cnt = underrun_cnt_q;
`else
    logic unused_empty;

    assign fill           = 1'b0;
    assign unused_empty   = i_fifol_empty & i_fifor_empty;
    assign o_underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_i2s_src_arbiter.sv
// Self-checking bench for i2s_src_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a transaction-level reference model.
module tb_i2s_src_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int B  = 4;
    localparam int IW = $clog2(N);
`ifdef I2S_ARB_UNDERRUN_EN
    localparam bit URUN = 1'b1;
`else
    localparam bit URUN = 1'b0;
`endif

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic           i_enable;
    logic [N-1:0]   i_en_mask;
    logic [N-1:0]   i_src_valid;
    logic [N*W-1:0] i_src_left;
    logic [N*W-1:0] i_src_right;
    logic [N-1:0]   o_src_ready;
    logic           i_fifol_full, i_fifor_full;
    logic           i_fifol_empty, i_fifor_empty;
    logic           o_txl_wr, o_txr_wr;
    logic [W-1:0]   o_txl_data, o_txr_data;
    logic           o_grant_valid;
    logic [IW-1:0]  o_grant_id;
    logic [15:0]    o_underrun_cnt;

    i2s_src_arbiter #(.NUM_SRC(N), .DATA_W(W), .BURST(B)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
        .i_en_mask      (i_en_mask),
        .i_src_valid    (i_src_valid),
        .i_src_left     (i_src_left),
        .i_src_right    (i_src_right),
        .o_src_ready    (o_src_ready),
        .i_fifol_full   (i_fifol_full),
        .i_fifor_full   (i_fifor_full),
        .i_fifol_empty  (i_fifol_empty),
        .i_fifor_empty  (i_fifor_empty),
        .o_txl_wr       (o_txl_wr),
        .o_txr_wr       (o_txr_wr),
        .o_txl_data     (o_txl_data),
        .o_txr_data     (o_txr_data),
        .o_grant_valid  (o_grant_valid),
        .o_grant_id     (o_grant_id),
        .o_underrun_cnt (o_underrun_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the FIFOs and how many pairs they may still send.
    bit           m_busy;
    int           m_owner, m_left, m_last, m_urun;
    logic [N-1:0] e_elig, e_ready;
    logic [W-1:0] e_l, e_r;
    bit           e_wr, e_gv, e_ok, e_fill;
    int           e_gid;

    // Observations of the DUT used by the directed scenarios.
    int wr_count;
    int grant_log[$];
    bit prev_gv;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_left  = 0;
        m_last  = N - 1;
        m_urun  = 0;
    endtask

    task automatic model_eval();
        e_elig  = {N{i_enable}} & i_en_mask & i_src_valid;
        e_ready = '0;
        e_wr    = 1'b0;
        e_ok    = 1'b0;
        e_fill  = 1'b0;
        e_l     = '0;
        e_r     = '0;
        e_gv    = m_busy;
        e_gid   = m_busy ? m_owner : 0;
        if (m_busy) begin
            e_ok = e_elig[m_owner] && !i_fifol_full && !i_fifor_full;
            if (e_ok) begin
                e_ready[m_owner] = 1'b1;
                e_wr = 1'b1;
                e_l  = i_src_left[m_owner*W +: W];
                e_r  = i_src_right[m_owner*W +: W];
            end
        end else if (URUN && i_enable && i_fifol_empty && i_fifor_empty && e_elig == '0) begin
            e_fill = 1'b1;
            e_wr   = 1'b1;
        end
    endtask

    task automatic model_step();
        int k;
        if (m_busy) begin
            if (!e_elig[m_owner]) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end else if (e_ok) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end
        end else if (e_elig != '0) begin
            k = m_last;
            do k = (k + 1) % N; while (!e_elig[k]);
            m_owner = k;
            m_left  = B;
            m_busy  = 1'b1;
        end else if (e_fill && m_urun < 65535) begin
            m_urun++;
        end
    endtask

    // Called at a falling edge: drive, compare mid-cycle, then advance one clock.
    task automatic cycle(input bit en, input logic [N-1:0] mask, input logic [N-1:0] valid,
                         input bit fl, input bit fr, input bit el, input bit er);
        i_enable      = en;
        i_en_mask     = mask;
        i_src_valid   = valid;
        i_fifol_full  = fl;
        i_fifor_full  = fr;
        i_fifol_empty = el;
        i_fifor_empty = er;
        for (int k = 0; k < N; k++) begin
            i_src_left[k*W +: W]  = $urandom();
            i_src_right[k*W +: W] = $urandom();
        end
        #1;
        model_eval();
        check("grant_valid",  o_grant_valid,  e_gv);
        check("grant_id",     o_grant_id,     e_gid);
        check("src_ready",    o_src_ready,    e_ready);
        check("txl_wr",       o_txl_wr,       e_wr);
        check("txr_wr",       o_txr_wr,       e_wr);
        check("txl_data",     o_txl_data,     e_l);
        check("txr_data",     o_txr_data,     e_r);
        check("underrun_cnt", o_underrun_cnt, m_urun);
        if (o_txl_wr) wr_count++;
        if (o_grant_valid && !prev_gv) grant_log.push_back(int'(o_grant_id));
        prev_gv = o_grant_valid;
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
    endtask

    // Asserted between clock edges so the asynchronous path is exercised.
    task automatic do_reset();
        i_enable    = 1'b0;
        i_src_valid = '0;
        i_rst_n     = 1'b0;
        #1;
        check("rst_grant_valid", o_grant_valid,  1'b0);
        check("rst_grant_id",    o_grant_id,     '0);
        check("rst_src_ready",   o_src_ready,    '0);
        check("rst_txl_wr",      o_txl_wr,       1'b0);
        check("rst_txr_wr",      o_txr_wr,       1'b0);
        check("rst_underrun",    o_underrun_cnt, '0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        wr_count = 0;
        grant_log.delete();
        prev_gv = 1'b0;
    endtask

    initial begin
        int exp_rr[5];
        int exp_alt[4];
        i_rst_n       = 1'b0;
        i_enable      = 1'b0;
        i_en_mask     = '0;
        i_src_valid   = '0;
        i_src_left    = '0;
        i_src_right   = '0;
        i_fifol_full  = 1'b0;
        i_fifor_full  = 1'b0;
        i_fifol_empty = 1'b0;
        i_fifor_empty = 1'b0;
        @(negedge i_clk);
        do_reset();

        // Lone source 0: two bursts separated by one arbitration cycle.
        repeat (10) cycle(1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s1_writes", wr_count, 8);
        check("s1_grants", grant_log.size(), 2);

        // All sources busy: strict rotation, four pairs each.
        do_reset();
        repeat (25) cycle(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_rr = '{0, 1, 2, 3, 0};
        check("s2_writes", wr_count, 20);
        check("s2_grants", grant_log.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size()) check("s2_order", grant_log[i], exp_rr[i]);

        // Left FIFO full mid-burst: hold, then finish the remaining two pairs.
        do_reset();
        repeat (3) cycle(1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s3_before_full", wr_count, 2);
        repeat (3) cycle(1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        check("s3_during_full", wr_count, 2);
        repeat (2) cycle(1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s3_writes", wr_count, 4);
        check("s3_grants", grant_log.size(), 1);

        // Masked sources: only 1 and 3 alternate.
        do_reset();
        repeat (20) cycle(1'b1, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_alt = '{1, 3, 1, 3};
        check("s4_writes", wr_count, 16);
        check("s4_grants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size()) check("s4_order", grant_log[i], exp_alt[i]);

        // Global enable dropped after two pairs.
        do_reset();
        repeat (3) cycle(1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s5_writes", wr_count, 2);
        check("s5_grants", grant_log.size(), 1);

        // Reset in the middle of a burst.
        do_reset();
        repeat (3) cycle(1'b1, 4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s5b_granted", o_grant_valid, 1'b1);
        do_reset();

        // Starved FIFOs with nothing to send.
        repeat (5) cycle(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        check("s6_writes", wr_count, URUN ? 5 : 0);
        #1;
        check("s6_urun_cnt", o_underrun_cnt, URUN ? 5 : 0);
        @(negedge i_clk);

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 19) != 0,
                      ($urandom_range(0, 3) == 0) ? N'($urandom()) : {N{1'b1}},
                      N'($urandom()),
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 2) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
